ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter: REG_AW, 5, register-address width.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 valid_i  input  1  ID stage holds a real instruction.
REQ-005 RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i  input  1 each  decoded ID-stage control.
REQ-006 ALUOp_i  input  2  decoded ALU class: 00 add, 01 sub/compare, 10 R-format funct.
REQ-007 rs1_i, rs2_i, rd_i  input  REG_AW each  ID-stage register indices.
REQ-008 flush_i  input  1  squash the current ID instruction.
REQ-009 ALUOp_ex_o  output  2  EX-stage ALU class.
REQ-010 ALUSrc_ex_o  output  1  EX-stage operand-B select.
REQ-011 MemRead_mem_o, MemWrite_mem_o  output  1 each  MEM-stage memory strobes.
REQ-012 RegWrite_wb_o, MemToReg_wb_o  output  1 each  WB-stage write controls.
REQ-013 rd_wb_o  output  REG_AW  WB-stage destination.
REQ-014 ForwardA_o, ForwardB_o  output  2 each  EX operand source: 00 register file, 01 WB, 10 MEM.
REQ-015 stall_o  output  1  load-use hazard: freeze PC and IF/ID.

Function
REQ-016 Three stage registers SHALL exist: ID/EX, EX/MEM, MEM/WB.
- Each holds valid, rd, and the control fields still needed downstream.
- ID/EX additionally holds rs1 and rs2.
REQ-017 Latency: ID controls SHALL appear at EX outputs 1 cycle after capture, MEM outputs 2 cycles, WB outputs 3 cycles.
REQ-018 A bubble SHALL be all control bits 0, valid 0, rd 0.
REQ-019 stall_o SHALL be combinational and asserted when all hold:
- valid_i = 1
- ID/EX valid = 1 and ID/EX MemRead = 1
- ID/EX rd != 0
- ID/EX rd equals rs1_i or rs2_i
REQ-020 While stall_o = 1: ID/EX SHALL load a bubble; EX/MEM and MEM/WB SHALL advance normally.
REQ-021 When flush_i = 1, ID/EX SHALL load a bubble regardless of stall_o.
REQ-022 When valid_i = 0, ID/EX SHALL load a bubble.
REQ-023 Outputs SHALL be gated by their stage's valid bit: an invalid stage drives 0 on all its outputs.
REQ-024 ForwardA_o SHALL be:
- 10 if EX/MEM valid, RegWrite = 1, rd != 0 and rd == ID/EX rs1;
- else 01 if the same conditions hold for MEM/WB;
- else 00.
REQ-025 ForwardB_o SHALL follow REQ-024 using ID/EX rs2.
REQ-026 If both MEM and WB match, MEM priority (10) SHALL win.
REQ-027 Register 0 SHALL never produce forwarding or a stall.
REQ-028 Branch_i SHALL be carried only to ID/EX and never cause a register write or memory access downstream.
REQ-029 Stall and flush in the same cycle SHALL produce exactly one bubble, with no duplicate instruction.

Reset
REQ-030 While rst_i = 0, all three stage registers SHALL clear to bubble immediately (asynchronously).
REQ-031 Consequently all outputs SHALL read 0, including ForwardA_o, ForwardB_o and stall_o.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight instructions; no WB write after release.
REQ-033 First capture after reset release SHALL occur on the first rising clk_i edge.

Structure
REQ-034 A shared package SHALL hold:
- ALUOp encodings (00/01/10);
- forward-select encodings (00/01/10);
- opcode constants (R-format 0110011, addi 0010011, lw 0000011, sw 0100011, beq 1100011);
- the stage-register control bundle type.
REQ-035 Forwarding comparison SHALL be one sub-module, ctrl_pipe_fwd, instantiated once per operand.

Verification
REQ-036 Reset release, then R-format add (RegWrite=1, ALUOp=10, rd=5) -> ALUOp_ex_o=10 at +1 cycle; RegWrite_wb_o=1 and rd_wb_o=5 at +3 cycles.
REQ-037 lw rd=3, next instruction with rs1=3 -> stall_o=1 for one cycle; EX shows a bubble; then ForwardA_o=01 when the dependent instruction reaches EX.
REQ-038 addi rd=4, then add rs1=4 rs2=4 -> ForwardA_o=ForwardB_o=10 in the dependent instruction's EX cycle.
REQ-039 Two writes to rd=7 back-to-back, then a reader of rs2=7 -> ForwardB_o=10 (MEM priority).
REQ-040 Writer rd=0, reader rs1=0 -> ForwardA_o=00; lw rd=0 with dependent instruction -> stall_o=0.
REQ-041 sw followed by flush_i=1 on the next ID instruction, with rst_i pulsed low mid-pipeline -> flushed slot shows all-0 outputs; all outputs 0 immediately on rst_i=0; no WB write after release.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the pipeline control block: ALU class and
// forward-select encodings, opcode constants and the ID/EX control bundle.
package ctrl_pipe_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ADDI  = 7'b0010011;
    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        valid:      1'b0,
        reg_write:  1'b0,
        mem_to_reg: 1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        alu_src:    1'b0,
        branch:     1'b0,
        alu_op:     2'b00
    };

    // The younger producer (MEM) always beats the older one (WB).
    function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
        logic [1:0] sel;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_pipe_fwd.sv
// Operand-source selection for one EX operand: compares the operand's
// source register against the MEM and WB destinations.
module ctrl_pipe_fwd
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_AW = 5
)
(
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] rs,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        sel
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    logic mem_hit_s;
    logic wb_hit_s;

    // Producer match per stage; register 0 never forwards.
    always_comb begin
        mem_hit_s = mem_valid & mem_reg_write & (mem_rd != REG_ZERO) & (mem_rd == rs);
        wb_hit_s  = wb_valid  & wb_reg_write  & (wb_rd  != REG_ZERO) & (wb_rd  == rs);
    end

    // An empty EX stage selects the register file.
    always_comb begin
        if (ex_valid) begin
            sel = fwd_sel(mem_hit_s, wb_hit_s);
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipeline control: ID/EX, EX/MEM and MEM/WB control registers with
// load-use stall detection, flush handling and EX operand forwarding.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_AW = 5
)
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              RegWrite_i,
    input  logic              MemToReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              ALUSrc_i,
    input  logic              Branch_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              flush_i,
    output logic [1:0]        ALUOp_ex_o,
    output logic              ALUSrc_ex_o,
    output logic              MemRead_mem_o,
    output logic              MemWrite_mem_o,
    output logic              RegWrite_wb_o,
    output logic              MemToReg_wb_o,
    output logic [REG_AW-1:0] rd_wb_o,
    output logic [1:0]        ForwardA_o,
    output logic [1:0]        ForwardB_o,
    output logic              stall_o
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    ctrl_t             id_ctrl_s;
    logic              stall_s;
    logic              load_bubble_s;

    ctrl_t             idex_ctrl_r;
    logic [REG_AW-1:0] idex_rd_r;
    logic [REG_AW-1:0] idex_rs1_r;
    logic [REG_AW-1:0] idex_rs2_r;

    logic              exmem_valid_r;
    logic              exmem_reg_write_r;
    logic              exmem_mem_to_reg_r;
    logic              exmem_mem_read_r;
    logic              exmem_mem_write_r;
    logic [REG_AW-1:0] exmem_rd_r;

    logic              memwb_valid_r;
    logic              memwb_reg_write_r;
    logic              memwb_mem_to_reg_r;
    logic [REG_AW-1:0] memwb_rd_r;

    // Gather the decoded ID-stage controls into one bundle.
    always_comb begin
        id_ctrl_s            = CTRL_BUBBLE;
        id_ctrl_s.valid      = valid_i;
        id_ctrl_s.reg_write  = RegWrite_i;
        id_ctrl_s.mem_to_reg = MemToReg_i;
        id_ctrl_s.mem_read   = MemRead_i;
        id_ctrl_s.mem_write  = MemWrite_i;
        id_ctrl_s.alu_src    = ALUSrc_i;
        id_ctrl_s.branch     = Branch_i;
        id_ctrl_s.alu_op     = ALUOp_i;
    end

    // Load-use hazard: a load in EX whose destination feeds the ID instruction.
    always_comb begin
        stall_s = 1'b0;
        if (valid_i && idex_ctrl_r.valid && idex_ctrl_r.mem_read &&
            (idex_rd_r != REG_ZERO) &&
            ((idex_rd_r == rs1_i) || (idex_rd_r == rs2_i))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
        load_bubble_s = flush_i | ~valid_i | stall_s;
    end

    // ID/EX register; stall, flush and empty ID all collapse to one bubble.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idex_ctrl_r <= CTRL_BUBBLE;
            idex_rd_r   <= REG_ZERO;
            idex_rs1_r  <= REG_ZERO;
            idex_rs2_r  <= REG_ZERO;
        end else if (load_bubble_s) begin
            idex_ctrl_r <= CTRL_BUBBLE;
            idex_rd_r   <= REG_ZERO;
            idex_rs1_r  <= REG_ZERO;
            idex_rs2_r  <= REG_ZERO;
        end else begin
            idex_ctrl_r <= id_ctrl_s;
            idex_rd_r   <= rd_i;
            idex_rs1_r  <= rs1_i;
            idex_rs2_r  <= rs2_i;
        end
    end

    // EX/MEM register; a branch is stripped of any write or memory strobe here.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exmem_valid_r      <= 1'b0;
            exmem_reg_write_r  <= 1'b0;
            exmem_mem_to_reg_r <= 1'b0;
            exmem_mem_read_r   <= 1'b0;
            exmem_mem_write_r  <= 1'b0;
            exmem_rd_r         <= REG_ZERO;
        end else begin
            exmem_valid_r      <= idex_ctrl_r.valid;
            exmem_reg_write_r  <= idex_ctrl_r.valid & idex_ctrl_r.reg_write  & ~idex_ctrl_r.branch;
            exmem_mem_to_reg_r <= idex_ctrl_r.valid & idex_ctrl_r.mem_to_reg & ~idex_ctrl_r.branch;
            exmem_mem_read_r   <= idex_ctrl_r.valid & idex_ctrl_r.mem_read   & ~idex_ctrl_r.branch;
            exmem_mem_write_r  <= idex_ctrl_r.valid & idex_ctrl_r.mem_write  & ~idex_ctrl_r.branch;
            exmem_rd_r         <= idex_rd_r;
        end
    end

    // MEM/WB register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            memwb_valid_r      <= 1'b0;
            memwb_reg_write_r  <= 1'b0;
            memwb_mem_to_reg_r <= 1'b0;
            memwb_rd_r         <= REG_ZERO;
        end else begin
            memwb_valid_r      <= exmem_valid_r;
            memwb_reg_write_r  <= exmem_reg_write_r;
            memwb_mem_to_reg_r <= exmem_mem_to_reg_r;
            memwb_rd_r         <= exmem_rd_r;
        end
    end

    ctrl_pipe_fwd #(.REG_AW(REG_AW)) u_fwd_a (
        .ex_valid      (idex_ctrl_r.valid),
        .rs            (idex_rs1_r),
        .mem_valid     (exmem_valid_r),
        .mem_reg_write (exmem_reg_write_r),
        .mem_rd        (exmem_rd_r),
        .wb_valid      (memwb_valid_r),
        .wb_reg_write  (memwb_reg_write_r),
        .wb_rd         (memwb_rd_r),
        .sel           (ForwardA_o)
    );

    ctrl_pipe_fwd #(.REG_AW(REG_AW)) u_fwd_b (
        .ex_valid      (idex_ctrl_r.valid),
        .rs            (idex_rs2_r),
        .mem_valid     (exmem_valid_r),
        .mem_reg_write (exmem_reg_write_r),
        .mem_rd        (exmem_rd_r),
        .wb_valid      (memwb_valid_r),
        .wb_reg_write  (memwb_reg_write_r),
        .wb_rd         (memwb_rd_r),
        .sel           (ForwardB_o)
    );

    // Stage outputs, each forced to 0 when its stage holds no instruction.
    always_comb begin
        stall_o = stall_s;
        if (idex_ctrl_r.valid) begin
            ALUOp_ex_o  = idex_ctrl_r.alu_op;
            ALUSrc_ex_o = idex_ctrl_r.alu_src;
        end else begin
            ALUOp_ex_o  = 2'b00;
            ALUSrc_ex_o = 1'b0;
        end
        if (exmem_valid_r) begin
            MemRead_mem_o  = exmem_mem_read_r;
            MemWrite_mem_o = exmem_mem_write_r;
        end else begin
            MemRead_mem_o  = 1'b0;
            MemWrite_mem_o = 1'b0;
        end
        if (memwb_valid_r) begin
            RegWrite_wb_o = memwb_reg_write_r;
            MemToReg_wb_o = memwb_mem_to_reg_r;
            rd_wb_o       = memwb_rd_r;
        end else begin
            RegWrite_wb_o = 1'b0;
            MemToReg_wb_o = 1'b0;
            rd_wb_o       = REG_ZERO;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed hazard scenarios followed by
// random instruction streams, all compared against a queue-based model.
module tb_ctrl_pipe;
    import ctrl_pipe_pkg::*;

    typedef struct packed {
        logic       v;
        logic       rw;
        logic       m2r;
        logic       mr;
        logic       mw;
        logic       asrc;
        logic       br;
        logic [1:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ins_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       valid_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i;
    logic [1:0] ALUOp_i;
    logic [4:0] rs1_i, rs2_i, rd_i;
    logic       flush_i;
    logic [1:0] ALUOp_ex_o;
    logic       ALUSrc_ex_o, MemRead_mem_o, MemWrite_mem_o, RegWrite_wb_o, MemToReg_wb_o;
    logic [4:0] rd_wb_o;
    logic [1:0] ForwardA_o, ForwardB_o;
    logic       stall_o;

    int n_checks = 0;
    int n_errors = 0;

    // Instructions occupying EX (0), MEM (1) and WB (2); bubbles are all-zero.
    ins_t pipe [3];

    ctrl_pipe #(.REG_AW(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
        .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .Branch_i(Branch_i),
        .ALUOp_i(ALUOp_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i),
        .ALUOp_ex_o(ALUOp_ex_o), .ALUSrc_ex_o(ALUSrc_ex_o),
        .MemRead_mem_o(MemRead_mem_o), .MemWrite_mem_o(MemWrite_mem_o),
        .RegWrite_wb_o(RegWrite_wb_o), .MemToReg_wb_o(MemToReg_wb_o), .rd_wb_o(rd_wb_o),
        .ForwardA_o(ForwardA_o), .ForwardB_o(ForwardB_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic ins_t nop();
        ins_t t = '0;
        return t;
    endfunction

    function automatic ins_t mk(input logic [6:0] opc, input int s1, input int s2, input int d);
        ins_t t = '0;
        t.v   = 1'b1;
        t.rs1 = 5'(s1);
        t.rs2 = 5'(s2);
        t.rd  = 5'(d);
        case (opc)
            OPC_RTYPE: begin t.rw = 1'b1; t.op = ALUOP_RTYPE; end
            OPC_ADDI:  begin t.rw = 1'b1; t.asrc = 1'b1; t.op = ALUOP_ADD; end
            OPC_LW:    begin t.rw = 1'b1; t.m2r = 1'b1; t.mr = 1'b1; t.asrc = 1'b1; end
            OPC_SW:    begin t.mw = 1'b1; t.asrc = 1'b1; end
            OPC_BEQ:   begin t.br = 1'b1; t.op = ALUOP_SUB; end
            default:   t = '0;
        endcase
        return t;
    endfunction

    function automatic ins_t rand_ins();
        logic [6:0] opcs [5];
        int k;
        opcs = '{OPC_RTYPE, OPC_ADDI, OPC_LW, OPC_SW, OPC_BEQ};
        k = $urandom_range(0, 5);
        if (k == 5) return nop();
        return mk(opcs[k], $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    endfunction

    function automatic bit model_stall(input ins_t id);
        ins_t ex = pipe[0];
        return id.v && ex.v && ex.mr && (ex.rd != 5'd0) && ((ex.rd == id.rs1) || (ex.rd == id.rs2));
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (!pipe[0].v || rs == 5'd0) return 2'b00;
        if (pipe[1].v && pipe[1].rw && pipe[1].rd == rs) return 2'b10;
        if (pipe[2].v && pipe[2].rw && pipe[2].rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic drive(input ins_t t, input bit fl);
        valid_i = t.v;  RegWrite_i = t.rw; MemToReg_i = t.m2r; MemRead_i = t.mr;
        MemWrite_i = t.mw; ALUSrc_i = t.asrc; Branch_i = t.br; ALUOp_i = t.op;
        rs1_i = t.rs1; rs2_i = t.rs2; rd_i = t.rd; flush_i = fl;
    endtask

    task automatic check_outputs(input ins_t id);
        check("alu_op_ex",    32'(ALUOp_ex_o),     32'(pipe[0].v ? pipe[0].op : 2'b00));
        check("alu_src_ex",   32'(ALUSrc_ex_o),    32'(pipe[0].v & pipe[0].asrc));
        check("mem_read_mem", 32'(MemRead_mem_o),  32'(pipe[1].v & pipe[1].mr));
        check("mem_write_mem",32'(MemWrite_mem_o), 32'(pipe[1].v & pipe[1].mw));
        check("reg_write_wb", 32'(RegWrite_wb_o),  32'(pipe[2].v & pipe[2].rw));
        check("mem2reg_wb",   32'(MemToReg_wb_o),  32'(pipe[2].v & pipe[2].m2r));
        check("rd_wb",        32'(rd_wb_o),        32'(pipe[2].v ? pipe[2].rd : 5'd0));
        check("fwd_a",        32'(ForwardA_o),     32'(model_fwd(pipe[0].rs1)));
        check("fwd_b",        32'(ForwardB_o),     32'(model_fwd(pipe[0].rs2)));
        check("stall",        32'(stall_o),        32'(model_stall(id)));
    endtask

    // One cycle: drive ID at the falling edge, check, then advance the model.
    task automatic step(input ins_t id, input bit fl, output bit st);
        ins_t ent;
        @(negedge clk_i);
        drive(id, fl);
        #1;
        check_outputs(id);
        st  = model_stall(id);
        ent = (fl || !id.v || st) ? nop() : id;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = ent;
    endtask

    // Reset pulse starting between clock edges, with an instruction presented.
    task automatic do_reset(input ins_t id);
        @(negedge clk_i);
        drive(id, 1'b0);
        rst_i = 1'b0;
        #1;
        pipe[0] = nop(); pipe[1] = nop(); pipe[2] = nop();
        check_outputs(id);
        @(posedge clk_i);
        #1;
        check_outputs(id);
        @(negedge clk_i);
        drive(nop(), 1'b0);
        rst_i = 1'b1;
    endtask

    initial begin
        bit   st;
        bit   fl;
        ins_t cur;
        ins_t dep;
        pipe[0] = nop(); pipe[1] = nop(); pipe[2] = nop();
        drive(nop(), 1'b0);

        // Reset state with a live instruction presented.
        do_reset(mk(OPC_LW, 1, 2, 3));

        // R-format add reaches EX after 1 cycle and WB after 3.
        step(mk(OPC_RTYPE, 1, 2, 5), 1'b0, st);
        step(nop(), 1'b0, st);
        check("r036_alu_op_ex", 32'(ALUOp_ex_o), 32'(ALUOP_RTYPE));
        step(nop(), 1'b0, st);
        step(nop(), 1'b0, st);
        check("r036_reg_write_wb", 32'(RegWrite_wb_o), 32'd1);
        check("r036_rd_wb", 32'(rd_wb_o), 32'd5);

        // Load-use: one stall, bubble in EX, then WB forwarding.
        step(mk(OPC_LW, 1, 2, 3), 1'b0, st);
        dep = mk(OPC_RTYPE, 3, 1, 6);
        step(dep, 1'b0, st);
        check("r037_stall", 32'(stall_o), 32'd1);
        step(dep, 1'b0, st);
        check("r037_stall_drop", 32'(stall_o), 32'd0);
        check("r037_bubble_src", 32'(ALUSrc_ex_o), 32'd0);
        step(nop(), 1'b0, st);
        check("r037_fwd_a", 32'(ForwardA_o), 32'(FWD_WB));

        // Back-to-back dependence forwards both operands from MEM.
        step(mk(OPC_ADDI, 1, 1, 4), 1'b0, st);
        step(mk(OPC_RTYPE, 4, 4, 8), 1'b0, st);
        step(nop(), 1'b0, st);
        check("r038_fwd_a", 32'(ForwardA_o), 32'(FWD_MEM));
        check("r038_fwd_b", 32'(ForwardB_o), 32'(FWD_MEM));

        // Two writers of r7: MEM copy wins.
        step(mk(OPC_ADDI, 1, 1, 7), 1'b0, st);
        step(mk(OPC_RTYPE, 1, 2, 7), 1'b0, st);
        step(mk(OPC_RTYPE, 1, 7, 9), 1'b0, st);
        step(nop(), 1'b0, st);
        check("r039_fwd_b", 32'(ForwardB_o), 32'(FWD_MEM));

        // Register 0 never forwards and never stalls.
        step(mk(OPC_ADDI, 1, 1, 0), 1'b0, st);
        step(mk(OPC_RTYPE, 0, 0, 10), 1'b0, st);
        step(nop(), 1'b0, st);
        check("r040_fwd_a_x0", 32'(ForwardA_o), 32'(FWD_RF));
        step(mk(OPC_LW, 1, 2, 0), 1'b0, st);
        step(mk(OPC_RTYPE, 0, 0, 11), 1'b0, st);
        check("r040_stall_x0", 32'(stall_o), 32'd0);

        // Store, then a flushed instruction, then reset mid-pipeline.
        step(mk(OPC_RTYPE, 1, 2, 12), 1'b0, st);
        step(mk(OPC_SW, 1, 2, 3), 1'b0, st);
        step(mk(OPC_RTYPE, 1, 2, 13), 1'b1, st);
        step(nop(), 1'b0, st);
        check("r041_flushed_ex", 32'(ALUOp_ex_o), 32'd0);
        check("r041_sw_mem", 32'(MemWrite_mem_o), 32'd1);
        check("r041_wb_live", 32'(RegWrite_wb_o), 32'd1);
        do_reset(mk(OPC_RTYPE, 1, 2, 14));
        for (int i = 0; i < 3; i++) begin
            step(nop(), 1'b0, st);
            check("r041_no_wb_after_rst", 32'(RegWrite_wb_o), 32'd0);
        end

        // Random streams; a stalled ID instruction is re-presented.
        st = 1'b0;
        cur = nop();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset(rand_ins());
                st = 1'b0;
            end
            if (!st) cur = rand_ins();
            fl = ($urandom_range(0, 7) == 0);
            step(cur, fl, st);
            if (fl) st = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
